// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// States: IDLE = waiting for a request | EXEC = ALU evaluating registered operands | RESP = result held for owner.
module alu_arbiter #(
   parameter int unsigned     W           = 4,
   parameter logic [W-1:0]    DIV0_RESULT = 4'hF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [2:0]   req0_oc,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [W-1:0] rsp0_f,
   output logic         rsp0_err,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [2:0]   req1_oc,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp1_f,
   output logic         rsp1_err,
   output logic [2:0]   alu_oc,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_f,
   output logic         busy
);

   localparam logic [2:0] OC_DIV = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         ptr;
   logic         owner;
   logic [2:0]   op_oc;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] res_f;
   logic         res_err;
   logic         grant0;
   logic         grant1;
   logic         rsp_take;

   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      rsp_take  = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || !ptr)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_take = owner ? rsp1_ready : rsp0_ready;
            if (rsp_take) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         owner   <= 1'b0;
         op_oc   <= '0;
         op_a    <= '0;
         op_b    <= '0;
         res_f   <= '0;
         res_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant0 || grant1) begin
            owner <= grant1;
            op_oc <= grant1 ? req1_oc : req0_oc;
            op_a  <= grant1 ? req1_a  : req0_a;
            op_b  <= grant1 ? req1_b  : req0_b;
         end
         if (state == EXEC) begin
            // The ALU quotient is undefined for b=0, so substitute a fixed code.
            if (op_oc == OC_DIV && op_b == '0) begin
               res_f   <= DIV0_RESULT;
               res_err <= 1'b1;
            end else begin
               res_f   <= alu_f;
               res_err <= 1'b0;
            end
         end
         if (rsp_take) begin
            ptr <= ~owner;
         end
      end
   end

   // Readys are gated by rst_n so they drop immediately while reset is held.
   assign req0_ready = grant0 & rst_n;
   assign req1_ready = grant1 & rst_n;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign rsp0_f     = res_f;
   assign rsp1_f     = res_f;
   assign rsp0_err   = res_err;
   assign rsp1_err   = res_err;
   assign alu_oc     = op_oc;
   assign alu_a      = op_a;
   assign alu_b      = op_b;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus random traffic against a transaction-level model.
module tb_alu_arbiter;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
   logic [2:0]   req0_oc;
   logic [W-1:0] req0_a, req0_b, rsp0_f;
   logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
   logic [2:0]   req1_oc;
   logic [W-1:0] req1_a, req1_b, rsp1_f;
   logic [2:0]   alu_oc;
   logic [W-1:0] alu_a, alu_b, alu_f;
   logic         busy;

   alu_arbiter #(.W(W), .DIV0_RESULT(4'hF)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oc(req0_oc),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oc(req1_oc),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_err(rsp1_err),
      .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_ref(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
      int ia, ib, r;
      ia = int'(x);
      ib = int'(y);
      case (o)
         3'd0:    r = (ia + ib) % 16;
         3'd1:    r = (ia - ib + 16) % 16;
         3'd2:    r = (ia * ib) % 16;
         3'd3:    r = (ib == 0) ? 0 : ia / ib;
         3'd4:    r = 15 - ia;
         3'd5:    r = ia ^ ib;
         3'd6:    r = ia | ib;
         default: r = ia & ib;
      endcase
      return r[3:0];
   endfunction

   // The shared ALU itself is part of the environment.
   assign alu_f = alu_ref(alu_oc, alu_a, alu_b);

   int n_tests = 0;
   int n_fail  = 0;

   bit          v[2];
   logic [2:0]  oc[2];
   logic [3:0]  a[2], b[2];
   bit          rr[2];
   int unsigned gen_rate[2];
   bit          rsp_rand;
   int unsigned rsp_rate;

   int          m_phase, m_prev, m_ptr, m_owner;
   logic [2:0]  m_oc;
   logic [3:0]  m_a, m_b, m_f;
   bit          m_err;

   int          grants[$];
   int          rsp_count = 0;
   logic [3:0]  last_f;
   bit          last_err;
   int          last_owner;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      req0_valid = v[0]; req0_oc = oc[0]; req0_a = a[0]; req0_b = b[0];
      req1_valid = v[1]; req1_oc = oc[1]; req1_a = a[1]; req1_b = b[1];
      rsp0_ready = rr[0]; rsp1_ready = rr[1];
   endtask

   task automatic reset_model();
      m_phase = 0; m_prev = 0; m_ptr = 0; m_owner = 0;
      m_oc = '0; m_a = '0; m_b = '0; m_f = '0; m_err = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_alu_oc", alu_oc, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_rsp0_f", rsp0_f, 0);
      check("rst_rsp1_err", rsp1_err, 0);
   endtask

   // One clock of stimulus, checking and model update; returns just after the falling edge.
   task automatic cycle();
      int g;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         if (!v[n] && $urandom_range(99) < gen_rate[n]) begin
            v[n]  = 1'b1;
            oc[n] = 3'($urandom_range(7));
            a[n]  = 4'($urandom_range(15));
            b[n]  = 4'($urandom_range(15));
         end
         if (rsp_rand) rr[n] = ($urandom_range(99) < rsp_rate);
      end
      drive();
      #1;
      g = -1;
      if (m_phase == 0) begin
         if (v[0] && v[1]) g = m_ptr;
         else if (v[0])    g = 0;
         else if (v[1])    g = 1;
      end
      check("req0_ready", req0_ready, g == 0);
      check("req1_ready", req1_ready, g == 1);
      check("busy", busy, m_phase != 0);
      check("rsp0_valid", rsp0_valid, m_phase == 2 && m_owner == 0);
      check("rsp1_valid", rsp1_valid, m_phase == 2 && m_owner == 1);
      check("alu_oc", alu_oc, m_oc);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      if (m_phase == 2) begin
         check("rsp_f", (m_owner == 1) ? rsp1_f : rsp0_f, m_f);
         check("rsp_err", (m_owner == 1) ? rsp1_err : rsp0_err, m_err);
      end
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      m_prev = m_phase;
      case (m_phase)
         0: if (g >= 0) begin
            m_owner = g; m_oc = oc[g]; m_a = a[g]; m_b = b[g];
            if (oc[g] == 3'd3 && b[g] == 4'd0) begin
               m_f = 4'hF; m_err = 1'b1;
            end else begin
               m_f = alu_ref(oc[g], a[g], b[g]); m_err = 1'b0;
            end
            v[g] = 1'b0;
            m_phase = 1;
         end
         1: m_phase = 2;
         default: if (rr[m_owner]) begin
            rsp_count++;
            last_f     = (m_owner == 1) ? rsp1_f : rsp0_f;
            last_err   = (m_owner == 1) ? rsp1_err : rsp0_err;
            last_owner = rsp1_valid ? 1 : 0;
            m_ptr   = 1 - m_owner;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic run_op(input int n, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                         input logic [3:0] ef, input bit ee);
      int start;
      bit done;
      start = rsp_count;
      done  = 1'b0;
      v[n] = 1'b1; oc[n] = o; a[n] = x; b[n] = y;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle();
         if (rsp_count != start) done = 1'b1;
      end
      check("op_done", done, 1);
      if (done) begin
         check("op_f", last_f, ef);
         check("op_err", last_err, ee);
         check("op_owner", last_owner, n);
      end
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 40 && !idle; i++) begin
         cycle();
         idle = (m_phase == 0) && !v[0] && !v[1];
      end
      check("drain", idle, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      v = '{1'b1, 1'b1}; rr = '{1'b0, 1'b0};
      oc = '{3'd0, 3'd0}; a = '{4'd0, 4'd0}; b = '{4'd0, 4'd0};
      gen_rate = '{0, 0}; rsp_rand = 1'b0; rsp_rate = 0;
      reset_model();
      drive();
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs();
      v = '{1'b0, 1'b0};
      drive();
      #1 rst_n = 1'b1;
      rr = '{1'b1, 1'b1};

      run_op(0, 3'd0, 4'd7, 4'd5, 4'hC, 1'b0);
      run_op(1, 3'd1, 4'd2, 4'd5, 4'hD, 1'b0);
      run_op(1, 3'd2, 4'd6, 4'd3, 4'h2, 1'b0);
      run_op(0, 3'd3, 4'd9, 4'd0, 4'hF, 1'b1);
      run_op(0, 3'd3, 4'd9, 4'd2, 4'h4, 1'b0);

      // Response backpressure on requester 1 while requester 0 waits.
      rr = '{1'b1, 1'b0};
      v[1] = 1'b1; oc[1] = 3'd5; a[1] = 4'hA; b[1] = 4'h3;
      m_prev = 0;
      for (int i = 0; i < 10 && m_prev != 2; i++) cycle();
      v[0] = 1'b1; oc[0] = 3'd0; a[0] = 4'd3; b[0] = 4'd4;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_rsp1_valid", rsp1_valid, 1);
         check("bp_rsp1_f", rsp1_f, 4'h9);
         check("bp_req0_ready", req0_ready, 0);
      end
      rr[1] = 1'b1;
      drain();

      // Reset while an op from requester 1 sits in EXEC.
      v[1] = 1'b1; oc[1] = 3'd0; a[1] = 4'd1; b[1] = 4'd1;
      m_prev = 0;
      for (int i = 0; i < 10 && m_prev != 1; i++) cycle();
      rst_n = 1'b0;
      v = '{1'b1, 1'b1};
      drive();
      #1;
      check_reset_outputs();
      reset_model();
      v = '{1'b0, 1'b0};
      drive();
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Contention: both continuously valid, grants must alternate starting at 0.
      grants.delete();
      gen_rate = '{100, 100};
      for (int i = 0; i < 40 && grants.size() < 4; i++) cycle();
      check("cont_count", grants.size() >= 4, 1);
      if (grants.size() >= 4) begin
         for (int k = 0; k < 4; k++) check("cont_grant", grants[k], k % 2);
      end
      gen_rate = '{0, 0};
      drain();

      gen_rate = '{40, 40};
      rsp_rand = 1'b1; rsp_rate = 60;
      repeat (400) cycle();
      gen_rate = '{0, 0};
      rsp_rand = 1'b0; rr = '{1'b1, 1'b1};
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
